mcu_subsys_dma: RTL and testbench
=================================

# mcu_subsys_dma

Word-copy DMA initiator for the MCU subsystem's native memory bus (valid/ready, 32-bit address/data, byte write strobes). It drives the bus as an initiator from the other end of the link that the ROM and RAM responders serve, and moves `len_words` 32-bit words from a source region to a destination region. Typical uses are streaming correlator result blocks into MCU RAM and copying firmware tables, without CPU load/store loops. It sits beside the CPU on the subsystem interconnect as a second bus master.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles a request may wait for `mem_ready` before abort; must be ≥2.
- `LEN_W`, default 16: width of the word-count input.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle request; sampled only when `busy`=0.
- `src_addr` in 32: source byte address; bits [1:0] ignored and forced to 0.
- `dst_addr` in 32: destination byte address; bits [1:0] ignored and forced to 0.
- `len_words` in LEN_W: number of words to copy.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a transfer, whether completed, zero-length or aborted.
- `err` out 1: valid with `done`; 1 means the transfer was aborted on timeout.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: responder acknowledge; may be combinational, including same-cycle with `mem_valid`.
- `mem_addr` out 32: request address, always word aligned.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'h0 for a read, 4'hF for a write.
- `mem_rdata` in 32: read data; valid only in the handshake cycle.

## Operation
- **FSM states:** IDLE, RD, WR.
- **IDLE:**
  - `start` with `len_words`≠0: latch `src`/`dst` pointers (low 2 bits cleared) and `remaining`=`len_words`, then go to RD.
  - `start` with `len_words`=0: pulse `done` next cycle with `err`=0 and stay in IDLE.
- **RD:** `mem_valid`=1, `mem_wstrb`=0, `mem_addr`=`src` pointer.
  - On a handshake (`mem_valid`&&`mem_ready`), capture `mem_rdata` into the data buffer and go to WR.
- **WR:** `mem_valid`=1, `mem_wstrb`=4'hF, `mem_addr`=`dst` pointer, `mem_wdata`=buffer.
  - On a handshake: `src`+=4, `dst`+=4, `remaining`-=1.
  - If `remaining` was 1, go to IDLE and pulse `done` with `err`=0; otherwise go to RD.
- **Pointer arithmetic:** 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- **Timeout counter:**
  - Clears on every state entry and every handshake; increments each cycle in RD/WR without `mem_ready`.
  - When the counter reaches `TIMEOUT_CYCLES`-1 with no ready: drop `mem_valid` next cycle, go to IDLE, pulse `done` with `err`=1. The partial copy is not rolled back.
- `start` while `busy`=1 is ignored, with no queuing.
- Handshakes in the same cycle as a timeout expiry complete normally; the handshake takes priority.

## Timing
- **Registered outputs:** all outputs are registered. Reset values: `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0, `done`=0, `err`=0. State resets to IDLE.
- **Request stability:** while `mem_valid`=1 and `mem_ready`=0, `mem_addr`, `mem_wdata` and `mem_wstrb` hold stable. `mem_valid` never drops without a handshake except on a timeout abort.
- **Start latency:** `start` sampled at edge 0 gives `mem_valid`=1 and `busy`=1 from cycle 1.
- **Zero-wait responder:** each word takes 2 cycles (RD, WR) with back-to-back requests and `mem_valid` held high. For N words, the last write handshake is in cycle 2N, `done` is high in cycle 2N+1, and `busy` falls in the same cycle.
- **Wait states:** each cycle of `mem_ready` low adds one cycle.
- **Reset mid-transfer:** `rst` asserted mid-transfer drops `mem_valid` immediately (async). No `done` is produced.

## Structure
- **Shared package `mcu_subsys_pkg`:**
  - `dma_state_t` enum {IDLE, RD, WR}.
  - Constants `MEM_WSTRB_READ`=4'h0 and `MEM_WSTRB_WORD`=4'hF.
  - Bus width constant `MEM_AW`=32.
- **Module layout:** single module with no sub-module; the timeout counter stays inline.

## Test plan
- **Zero-wait copy:** responder model with `mem_ready`=1; `src`=0x0000_0100, `dst`=0x0001_0000, `len`=4, source = 0xA0..0xA3 → 8 handshakes alternating read/write, destination holds 0xA0..0xA3, `done` at cycle 9, `err`=0.
- **Wait states:** `mem_ready` low for 3 cycles on every request, `len`=2 → address, data and strobe stable during stalls; `done` at cycle 1+4×4=17.
- **Zero length:** `len`=0 → no `mem_valid`, `done`=1 at cycle 1, `busy` stays 0.
- **Timeout:** `TIMEOUT_CYCLES`=8, responder never ready → `mem_valid` high for 8 cycles then low, `done`=1 and `err`=1; a fresh `start` afterwards succeeds.
- **Address wrap and ignored start:** `src`=0xFFFF_FFFC, `len`=2 → reads at 0xFFFF_FFFC then 0x0000_0000. A second `start` mid-transfer is ignored.
- **Async reset mid-transfer:** `rst` asserted during WR → all outputs go to 0 asynchronously and no `done` is produced.

Source files
------------

// File: rtl/mcu_subsys_pkg.sv
// ============================================================================
// Module      : mcu_subsys_pkg
// Description : Shared types and constants for the MCU subsystem native
//               memory bus and the word-copy DMA initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_subsys_pkg;

  // Native bus address/data width
  localparam int MEM_AW = 32;

  // Write-strobe encodings used on the native bus
  localparam logic [3:0] MEM_WSTRB_READ = 4'h0;
  localparam logic [3:0] MEM_WSTRB_WORD = 4'hF;

  // DMA sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

  // Clear the byte-offset bits so every request is word aligned
  function automatic logic [MEM_AW-1:0] word_align(input logic [MEM_AW-1:0] a);
    return a & {{(MEM_AW-2){1'b1}}, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_subsys_dma.sv
// ============================================================================
// Module      : mcu_subsys_dma
// Description : Word-copy DMA initiator on the MCU subsystem native bus.
//               Alternates one read and one write per word, with a per-request
//               timeout that aborts the transfer if the responder stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_subsys_dma
  import mcu_subsys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int LEN_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1
  localparam int               TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  dma_state_t        state_q;
  logic [MEM_AW-1:0] src_q;
  logic [MEM_AW-1:0] dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [TW-1:0]     tmo_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_valid_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [MEM_AW-1:0] mem_wdata_q;   // doubles as the read-data buffer
  logic [3:0]        mem_wstrb_q;

  // Pointers after the current word completes (32-bit modulo wrap)
  logic [MEM_AW-1:0] src_d;
  logic [MEM_AW-1:0] dst_d;
  logic              tmo_hit;

  assign src_d   = src_q + 32'd4;
  assign dst_d   = dst_q + 32'd4;
  assign tmo_hit = (tmo_q == TMO_LAST);

  // Sequencer: IDLE -> RD -> WR -> (RD | IDLE), with timeout abort to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= MEM_WSTRB_READ;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_words != '0) begin
              src_q       <= word_align(src_addr);
              dst_q       <= word_align(dst_addr);
              rem_q       <= len_words;
              tmo_q       <= '0;
              state_q     <= RD;
              busy_q      <= 1'b1;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= word_align(src_addr);
              mem_wstrb_q <= MEM_WSTRB_READ;
            end else begin
              // Zero-length request completes immediately without bus traffic
              done_q <= 1'b1;
            end
          end
        end

        RD: begin
          if (mem_ready) begin
            // Handshake wins over a coincident timeout expiry
            mem_wdata_q <= mem_rdata;
            mem_addr_q  <= dst_q;
            mem_wstrb_q <= MEM_WSTRB_WORD;
            tmo_q       <= '0;
            state_q     <= WR;
          end else if (tmo_hit) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= MEM_WSTRB_READ;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        WR: begin
          if (mem_ready) begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_q - 1'b1;
            tmo_q <= '0;
            if (rem_q == LEN_ONE) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              mem_valid_q <= 1'b0;
              mem_wstrb_q <= MEM_WSTRB_READ;
              done_q      <= 1'b1;
            end else begin
              state_q     <= RD;
              mem_addr_q  <= src_d;
              mem_wstrb_q <= MEM_WSTRB_READ;
            end
          end else if (tmo_hit) begin
            // Abort leaves already-written words in place
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= MEM_WSTRB_READ;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mcu_subsys_dma.sv
// ============================================================================
// Module      : tb_mcu_subsys_dma
// Description : Directed self-checking bench for the word-copy DMA initiator
//               with an address-driven responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_subsys_dma;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder behaviour: 0 = always ready, 1 = 3 wait cycles per request, 2 = never ready
  int       mode = 0;
  int       stall_cnt = 0;
  logic     mon_en = 1'b0;
  int       stab_viol = 0;
  int       done_cnt = 0;

  logic [3:0]  lg_strb[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];

  mcu_subsys_dma #(
    .TIMEOUT_CYCLES(8),
    .LEN_W         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len_words(len_words),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory contents as a pure function of the address
  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    else if (a == 32'hFFFF_FFFC)     return 32'h1111_1111;
    else if (a == 32'h0)             return 32'h2222_2222;
    else                             return {16'hDEAD, a[15:0]};
  endfunction

  assign mem_rdata = src_word(mem_addr);
  assign mem_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (mem_valid && stall_cnt == 3) : 1'b0;

  // Responder bookkeeping and transaction log
  always @(posedge clk) begin
    if (mem_valid && !mem_ready) stall_cnt <= stall_cnt + 1;
    else                         stall_cnt <= 0;
    if (mem_valid && mem_ready) begin
      lg_strb.push_back(mem_wstrb);
      lg_addr.push_back(mem_addr);
      lg_data.push_back((mem_wstrb == 4'hF) ? mem_wdata : mem_rdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Request-stability monitor: a stalled request must hold everything
  logic        p_valid, p_ready;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;
  initial begin
    p_valid = 1'b0; p_ready = 1'b0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
  end
  always @(negedge clk) begin
    if (mon_en && p_valid && !p_ready) begin
      if (!mem_valid || mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb)
        stab_viol = stab_viol + 1;
    end
    p_valid = mem_valid; p_ready = mem_ready;
    p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start request; returns at #1 after edge 0, i.e. in cycle 1
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    src_addr  = s;
    dst_addr  = d;
    len_words = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Step cycle by cycle until done, counting cycles with mem_valid high
  task automatic run_until_done(input int first, input int limit,
                                output int dcyc, output logic e, output int vcnt);
    dcyc = -1;
    e    = 1'bx;
    vcnt = 0;
    for (int c = first; c <= limit; c++) begin
      if (done) begin
        dcyc = c;
        e    = err;
        break;
      end
      if (mem_valid) vcnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int       dc;
    int       vc;
    int       base;
    int       dbase;
    logic     e;

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    check("rst_addr",  mem_addr,           32'd0);
    check("rst_wdata", mem_wdata,          32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- Zero-wait copy of 4 words ----
    mode = 0;
    base = lg_addr.size();
    do_start(32'h0000_0100, 32'h0001_0000, 16'd4);
    check("zw_busy_c1",  {31'd0, busy},      32'd1);
    check("zw_valid_c1", {31'd0, mem_valid}, 32'd1);
    check("zw_addr_c1",  mem_addr,           32'h100);
    run_until_done(1, 40, dc, e, vc);
    check("zw_done_cyc", dc,                 32'd9);
    check("zw_err",      {31'd0, e},         32'd0);
    check("zw_busy_end", {31'd0, busy},      32'd0);
    check("zw_vcycles",  vc,                 32'd8);
    check("zw_nhs",      lg_addr.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < lg_addr.size()) begin
        if (i % 2 == 0) begin
          check("zw_rd_addr", lg_addr[base+i], 32'h100 + 32'(4 * (i / 2)));
          check("zw_rd_strb", {28'd0, lg_strb[base+i]}, 32'h0);
        end else begin
          check("zw_wr_addr", lg_addr[base+i], 32'h1_0000 + 32'(4 * (i / 2)));
          check("zw_wr_data", lg_data[base+i], 32'hA0 + 32'(i / 2));
          check("zw_wr_strb", {28'd0, lg_strb[base+i]}, 32'hF);
        end
      end
    end
    @(posedge clk);
    #1;
    check("zw_done_pulse", {31'd0, done}, 32'd0);

    // ---- Wait states: 3 stall cycles per request, 2 words ----
    mode = 1;
    base = lg_addr.size();
    stab_viol = 0;
    mon_en = 1'b1;
    do_start(32'h0000_0100, 32'h0002_0000, 16'd2);
    run_until_done(1, 60, dc, e, vc);
    mon_en = 1'b0;
    check("ws_done_cyc", dc,              32'd17);
    check("ws_err",      {31'd0, e},      32'd0);
    check("ws_stable",   stab_viol,       32'd0);
    check("ws_nhs",      lg_addr.size() - base, 32'd4);
    if (base + 3 < lg_addr.size()) begin
      check("ws_rd1_addr", lg_addr[base+2], 32'h104);
      check("ws_wr0_addr", lg_addr[base+1], 32'h2_0000);
      check("ws_wr0_data", lg_data[base+1], 32'hA0);
      check("ws_wr1_addr", lg_addr[base+3], 32'h2_0004);
      check("ws_wr1_data", lg_data[base+3], 32'hA1);
    end

    // ---- Zero length ----
    mode = 0;
    base = lg_addr.size();
    @(posedge clk);
    #1;
    do_start(32'h0000_0100, 32'h0001_0000, 16'd0);
    check("zl_done",  {31'd0, done},      32'd1);
    check("zl_err",   {31'd0, err},       32'd0);
    check("zl_busy",  {31'd0, busy},      32'd0);
    check("zl_valid", {31'd0, mem_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("zl_done_pulse", {31'd0, done},   32'd0);
    check("zl_busy2",      {31'd0, busy},   32'd0);
    check("zl_nhs",        lg_addr.size() - base, 32'd0);

    // ---- Timeout with a responder that never answers ----
    mode = 2;
    base = lg_addr.size();
    do_start(32'h0000_0200, 32'h0003_0000, 16'd3);
    run_until_done(1, 40, dc, e, vc);
    check("to_done_cyc", dc,                 32'd9);
    check("to_err",      {31'd0, e},         32'd1);
    check("to_vcycles",  vc,                 32'd8);
    check("to_valid_lo", {31'd0, mem_valid}, 32'd0);
    check("to_busy_lo",  {31'd0, busy},      32'd0);
    check("to_nhs",      lg_addr.size() - base, 32'd0);

    // Fresh start after the abort
    mode = 0;
    @(posedge clk);
    #1;
    base = lg_addr.size();
    do_start(32'h0000_0104, 32'h0003_0000, 16'd1);
    run_until_done(1, 20, dc, e, vc);
    check("ta_done_cyc", dc,         32'd3);
    check("ta_err",      {31'd0, e}, 32'd0);
    check("ta_nhs",      lg_addr.size() - base, 32'd2);
    if (base + 1 < lg_addr.size()) begin
      check("ta_wr_addr", lg_addr[base+1], 32'h3_0000);
      check("ta_wr_data", lg_data[base+1], 32'hA1);
    end

    // ---- Address wrap with an ignored mid-transfer start ----
    @(posedge clk);
    #1;
    base = lg_addr.size();
    do_start(32'hFFFF_FFFE, 32'h0004_0001, 16'd2);
    check("wr_addr_c1", mem_addr, 32'hFFFF_FFFC);
    src_addr = 32'h0000_0500; dst_addr = 32'h0005_0000; len_words = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_until_done(2, 30, dc, e, vc);
    check("wr_done_cyc", dc,         32'd5);
    check("wr_err",      {31'd0, e}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("wr_valid_after", {31'd0, mem_valid}, 32'd0);
    check("wr_busy_after",  {31'd0, busy},      32'd0);
    check("wr_nhs",         lg_addr.size() - base, 32'd4);
    if (base + 3 < lg_addr.size()) begin
      check("wr_rd0_addr", lg_addr[base+0], 32'hFFFF_FFFC);
      check("wr_rd1_addr", lg_addr[base+2], 32'h0000_0000);
      check("wr_wr0_addr", lg_addr[base+1], 32'h0004_0000);
      check("wr_wr0_data", lg_data[base+1], 32'h1111_1111);
      check("wr_wr1_addr", lg_addr[base+3], 32'h0004_0004);
      check("wr_wr1_data", lg_data[base+3], 32'h2222_2222);
    end

    // ---- Asynchronous reset during WR ----
    do_start(32'h0000_0100, 32'h0006_0000, 16'd3);
    @(posedge clk);
    #1;
    check("ar_wstrb_wr", {28'd0, mem_wstrb}, 32'hF);
    check("ar_valid_wr", {31'd0, mem_valid}, 32'd1);
    dbase = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, mem_valid}, 32'd0);
    check("ar_busy",  {31'd0, busy},      32'd0);
    check("ar_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("ar_addr",  mem_addr,           32'd0);
    check("ar_wdata", mem_wdata,          32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ar_no_done", done_cnt - dbase, 32'd0);
    check("ar_idle",    {31'd0, mem_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
